// File: rtl/audio_source_sched_pkg.sv
// Shared audio types and default sizing for the CODEC/ROM sample path.
package audio_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PRIME = 2'd1,
    ARMED = 2'd2
  } sched_state_t;

  localparam int AUD_DATA_W    = 24;
  localparam int SND_ADDR_W    = 16;
  localparam int SND_LAST_ADDR = 47999;
  localparam int SND_ROM_LAT   = 2;

endpackage

// File: rtl/audio_source_sched_prefetch.sv
// ROM address counter, read-latency down-counter and one-sample prefetch register.
module audio_rom_prefetch
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUD_DATA_W,
  parameter int ADDR_W    = SND_ADDR_W,
  parameter int LAST_ADDR = SND_LAST_ADDR,
  parameter int ROM_LAT   = SND_ROM_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic              wrap,
  input  logic              clear,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              at_last
);

  localparam int CNT_W = $clog2(ROM_LAT + 1);

  logic [CNT_W-1:0] lat_cnt;

  // rom_q is sampleable on the edge where the counter steps from 1 to 0
  assign sample_valid = (lat_cnt == CNT_W'(1));
  assign at_last      = (rom_addr == ADDR_W'(LAST_ADDR));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rom_addr <= '0;
      lat_cnt  <= '0;
      sample   <= '0;
    end else if (start) begin
      rom_addr <= '0;
      lat_cnt  <= CNT_W'(ROM_LAT);
    end else if (advance) begin
      rom_addr <= wrap ? '0 : rom_addr + ADDR_W'(1);
      lat_cnt  <= CNT_W'(ROM_LAT);
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - CNT_W'(1);
      if (sample_valid) sample <= rom_q;
    end
  end

endmodule

// File: rtl/audio_source_sched.sv
// Chooses mic passthrough or ROM playback for the CODEC and sequences ROM reads.
module audio_source_sched
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUD_DATA_W,
  parameter int ADDR_W    = SND_ADDR_W,
  parameter int LAST_ADDR = SND_LAST_ADDR,
  parameter int ROM_LAT   = SND_ROM_LAT
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              src_sel,
  input  logic              loop_en,
  input  logic              play,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic              done
);

  sched_state_t      state, state_nxt;
  logic              hs, start, advance, wrap, clear, terminal;
  logic              sample_valid, at_last;
  logic [DATA_W-1:0] sample;

  assign hs    = read_ready & write_ready;
  assign read  = hs;
  assign write = hs;

  audio_rom_prefetch #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR),
    .ROM_LAT  (ROM_LAT)
  ) u_prefetch (
    .clk         (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .advance     (advance),
    .wrap        (wrap),
    .clear       (clear),
    .rom_q       (rom_q),
    .rom_addr    (rom_addr),
    .sample      (sample),
    .sample_valid(sample_valid),
    .at_last     (at_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= STOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!src_sel) begin
      state_nxt = STOP;
    end else begin
      case (state)
        STOP:    if (play) state_nxt = PRIME;
        PRIME:   if (play) state_nxt = PRIME;
                 else if (sample_valid) state_nxt = ARMED;
        ARMED:   if (play) state_nxt = PRIME;
                 else if (hs) state_nxt = (at_last && !loop_en) ? STOP : PRIME;
        default: state_nxt = STOP;
      endcase
    end
  end

  always_comb begin
    // play outranks an hs advance; leaving mic mode never counts as a finish
    terminal = src_sel && (state == ARMED) && !play && hs && at_last && !loop_en;
    start    = src_sel && play;
    advance  = src_sel && (state == ARMED) && !play && hs && !terminal;
    wrap     = at_last && loop_en;
    clear    = !src_sel || terminal;
    busy     = (state != STOP);
    if (!src_sel) begin
      writedata_left  = readdata_left;
      writedata_right = readdata_right;
    end else if (state == STOP) begin
      writedata_left  = '0;
      writedata_right = '0;
    end else begin
      writedata_left  = sample;
      writedata_right = sample;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) done <= 1'b0;
    else       done <= terminal;
  end

endmodule
